// File: rtl/ram_pkg.sv
// Shared types for the parametrised RW RAM and its init sequencer.
package ram_pkg;

    typedef enum logic {INIT, IDLE} ram_state_t;

endpackage

// File: rtl/ram_init_seq.sv
// Init sequencer: sweeps every word to zero after reset or on a clear request,
// raising busy for the duration of the sweep.
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              init_we_o,
    output logic [ADDR_W-1:0] init_addr_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    ram_state_t        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;

    // busy falls on the same edge that writes the last word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                INIT: begin
                    if (ptr_q == LastAddr) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (clr_i) begin
                        state_q <= INIT;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= INIT;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign init_we_o   = (state_q == INIT);
    assign init_addr_o = ptr_q;

endmodule

// File: rtl/ram_rw_param.sv
// Parametrised single-clock RAM with separate write/read ports, registered read
// with a valid pulse, and a hardware zeroing sweep after reset or clear.
module ram_rw_param
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)  // derived; do not override
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    output logic              busy_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    logic              user_we;
    logic              user_re;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_d;
    logic              dout_valid_q;

    ram_init_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .busy_o      (busy),
        .init_we_o   (init_we),
        .init_addr_o (init_addr)
    );

    // clr in IDLE drops any same-cycle user access
    always_comb begin
        user_we     = !busy && !clr_i && we_i;
        user_re     = !busy && !clr_i && re_i;
        wr_in_range = (32'(wr_addr_i) < DEPTH);
        rd_in_range = (32'(rd_addr_i) < DEPTH);

        mem_we    = init_we || (user_we && wr_in_range);
        mem_waddr = init_we ? init_addr : wr_addr_i;
        mem_wdata = init_we ? '0 : din_i;

        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (user_re) begin
            dout_valid_d = 1'b1;
            if (!rd_in_range) begin
                dout_d = '0;
            end else if (user_we && (wr_addr_i == rd_addr_i)) begin
                dout_d = din_i;
            end else begin
                dout_d = mem[rd_addr_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign busy_o       = busy;

endmodule

// File: tb/tb_ram_rw_param.sv
// Bench for ram_rw_param: a 4x4 instance tracked by a cycle model every cycle,
// plus a 5x8 instance exercised with directed out-of-range accesses.
module tb_ram_rw_param;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic       a_clr = 1'b0, a_we = 1'b0, a_re = 1'b0;
    logic [1:0] a_wa = '0, a_ra = '0;
    logic [3:0] a_din = '0;
    logic [3:0] a_dout;
    logic       a_valid, a_busy;

    logic       b_clr = 1'b0, b_we = 1'b0, b_re = 1'b0;
    logic [2:0] b_wa = '0, b_ra = '0;
    logic [7:0] b_din = '0;
    logic [7:0] b_dout;
    logic       b_valid, b_busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ram_rw_param #(.DATA_W(4), .DEPTH(4)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr), .we_i(a_we), .wr_addr_i(a_wa),
        .din_i(a_din), .re_i(a_re), .rd_addr_i(a_ra), .dout_o(a_dout),
        .dout_valid_o(a_valid), .busy_o(a_busy)
    );

    ram_rw_param #(.DATA_W(8), .DEPTH(5)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr), .we_i(b_we), .wr_addr_i(b_wa),
        .din_i(b_din), .re_i(b_re), .rd_addr_i(b_ra), .dout_o(b_dout),
        .dout_valid_o(b_valid), .busy_o(b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of instance A: sweep_left counts zeroing edges still owed.
    int         sweep_left = 4;
    logic [3:0] m [4];
    logic [3:0] e_dout  = '0;
    logic       e_valid = 1'b0;
    logic       e_busy  = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_left <= 4;
            e_dout     <= '0;
            e_valid    <= 1'b0;
            e_busy     <= 1'b1;
        end else if (sweep_left > 0) begin
            m[4 - sweep_left] <= '0;
            sweep_left        <= sweep_left - 1;
            e_valid           <= 1'b0;
            e_busy            <= (sweep_left > 1);
        end else if (a_clr) begin
            sweep_left <= 4;
            e_busy     <= 1'b1;
            e_valid    <= 1'b0;
        end else begin
            e_valid <= a_re;
            if (a_re) e_dout <= (a_we && a_wa == a_ra) ? a_din : m[a_ra];
            if (a_we) m[a_wa] <= a_din;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dout", 32'(a_dout), 32'(e_dout));
            check("model_valid", 32'(a_valid), 32'(e_valid));
            check("model_busy", 32'(a_busy), 32'(e_busy));
        end
    end

    task automatic a_cycle(input logic we, input logic [1:0] wa, input logic [3:0] din,
                           input logic re, input logic [1:0] ra, input logic clr);
        a_we = we; a_wa = wa; a_din = din; a_re = re; a_ra = ra; a_clr = clr;
        @(negedge clk);
        a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0;
    endtask

    task automatic b_cycle(input logic we, input logic [2:0] wa, input logic [7:0] din,
                           input logic re, input logic [2:0] ra);
        b_we = we; b_wa = wa; b_din = din; b_re = re; b_ra = ra;
        @(negedge clk);
        b_we = 1'b0; b_re = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(a_busy), 32'd1);
        check("rst_dout", 32'(a_dout), 32'd0);
        check("rst_valid", 32'(a_valid), 32'd0);

        // Test 1: 4-edge sweep, then all words read back as zero.
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sweep_busy", 32'(a_busy), (i < 3) ? 32'd1 : 32'd0);
        end
        check("b_busy_edge4", 32'(b_busy), 32'd1);
        @(negedge clk);
        check("b_busy_edge5", 32'(b_busy), 32'd0);
        for (int a = 0; a < 4; a++) begin
            a_cycle(1'b0, 2'd0, 4'd0, 1'b1, 2'(a), 1'b0);
            check("init_rd_dout", 32'(a_dout), 32'd0);
            check("init_rd_valid", 32'(a_valid), 32'd1);
        end

        // Test 2: write then read, then hold.
        a_cycle(1'b1, 2'd2, 4'hA, 1'b0, 2'd0, 1'b0);
        a_cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 1'b0);
        check("wr_rd_dout", 32'(a_dout), 32'hA);
        check("wr_rd_valid", 32'(a_valid), 32'd1);
        @(negedge clk);
        check("hold_valid", 32'(a_valid), 32'd0);
        check("hold_dout", 32'(a_dout), 32'hA);

        // Test 3: same-address write/read is write-first.
        a_cycle(1'b1, 2'd1, 4'h5, 1'b1, 2'd1, 1'b0);
        check("wfirst_dout", 32'(a_dout), 32'h5);

        // Test 4: fill, clear with a dropped write, everything reads zero.
        for (int a = 0; a < 4; a++) a_cycle(1'b1, 2'(a), 4'(a + 1), 1'b0, 2'd0, 1'b0);
        a_cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'd3, 1'b0);
        check("fill_rd3", 32'(a_dout), 32'h4);
        a_cycle(1'b1, 2'd0, 4'hF, 1'b1, 2'd0, 1'b1);
        check("clr_busy", 32'(a_busy), 32'd1);
        check("clr_valid", 32'(a_valid), 32'd0);
        check("clr_dout_hold", 32'(a_dout), 32'h4);
        for (int i = 0; i < 4; i++) begin
            a_cycle(1'b1, 2'd1, 4'h9, 1'b1, 2'd1, 1'b0);
            check("clr_sweep_busy", 32'(a_busy), (i < 3) ? 32'd1 : 32'd0);
            check("clr_sweep_valid", 32'(a_valid), 32'd0);
        end
        for (int a = 0; a < 4; a++) begin
            a_cycle(1'b0, 2'd0, 4'd0, 1'b1, 2'(a), 1'b0);
            check("post_clr_rd", 32'(a_dout), 32'd0);
        end

        // Test 5: reset in the middle of a sweep restarts it from scratch.
        a_cycle(1'b1, 2'd1, 4'h7, 1'b0, 2'd0, 1'b0);
        a_cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 1'b0);
        check("pre_rst_dout", 32'(a_dout), 32'h7);
        a_cycle(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_dout", 32'(a_dout), 32'd0);
        check("midrst_busy", 32'(a_busy), 32'd1);
        check("midrst_valid", 32'(a_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("resweep_busy", 32'(a_busy), (i < 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("b_idle", 32'(b_busy), 32'd0);

        // Test 6: DEPTH=5 instance, out-of-range writes discarded, reads give zero.
        b_cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd4);
        check("b_rd4_init", 32'(b_dout), 32'h00);
        check("b_rd4_valid", 32'(b_valid), 32'd1);
        b_cycle(1'b1, 3'd4, 8'h3C, 1'b0, 3'd0);
        b_cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd4);
        check("b_rd4_data", 32'(b_dout), 32'h3C);
        b_cycle(1'b1, 3'd6, 8'hFF, 1'b0, 3'd0);
        b_cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd6);
        check("b_rd6_dout", 32'(b_dout), 32'h00);
        check("b_rd6_valid", 32'(b_valid), 32'd1);
        b_cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd4);
        check("b_rd4_after", 32'(b_dout), 32'h3C);
        b_cycle(1'b1, 3'd6, 8'hAA, 1'b1, 3'd6);
        check("b_oor_wfirst", 32'(b_dout), 32'h00);
        check("b_oor_wf_valid", 32'(b_valid), 32'd1);
        @(negedge clk);
        check("b_idle_valid", 32'(b_valid), 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
